// File: rtl/return_addr_stack.sv
// return_addr_stack
//   Return-address predictor stack. A circular buffer of DEPTH 64-bit entries
//   with a top pointer and an entry count. A push that finds the stack full
//   overwrites the oldest entry, because the pointer wraps onto it.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset; clears pointer, count, pulses, entries
//   push       BL executed: push_addr becomes the new top
//   push_addr  64-bit return address
//   pop        return consumed: remove the top entry
//   flush      pipeline flush: discard all entries (wins over push/pop)
//   top_addr   entry at the pointer, or 0 when the stack is empty
//   top_valid  stack non-empty
//   count      number of valid entries, 0..DEPTH
//   full       count == DEPTH
//   overflow   one-cycle pulse: a push discarded the oldest entry
//   underflow  one-cycle pulse: a pop found the stack empty
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [63:0]   push_addr,
    input  logic          pop,
    input  logic          flush,
    output logic [63:0]   top_addr,
    output logic          top_valid,
    output logic [PW:0]   count,
    output logic          full,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [63:0]   entries [DEPTH];
    logic [PW-1:0] topPtr;
    logic [PW-1:0] ptrNext;
    logic [PW:0]   countNext;
    logic          overflowNext;
    logic          underflowNext;
    logic          wrEn;
    logic [PW-1:0] wrIdx;
    logic          isEmpty;

    assign isEmpty = (count == '0);

    always_comb begin
        ptrNext       = topPtr;
        countNext     = count;
        overflowNext  = 1'b0;
        underflowNext = 1'b0;
        wrEn          = 1'b0;
        wrIdx         = topPtr;
        if (flush) begin
            ptrNext   = '0;
            countNext = '0;
        end else if (push && pop && !isEmpty) begin
            // Return and call in one cycle: the top is swapped in place.
            wrEn = 1'b1;
        end else if (push) begin
            // Also covers push+pop on an empty stack, which acts as a plain push.
            // PW-bit arithmetic gives the modulo-DEPTH wrap for free.
            ptrNext = topPtr + PW'(1);
            wrIdx   = ptrNext;
            wrEn    = 1'b1;
            if (count == FULL_COUNT) begin
                overflowNext = 1'b1;
            end else begin
                countNext = count + (PW+1)'(1);
            end
        end else if (pop) begin
            if (isEmpty) begin
                underflowNext = 1'b1;
            end else begin
                ptrNext   = topPtr - PW'(1);
                countNext = count - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            topPtr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            topPtr    <= ptrNext;
            count     <= countNext;
            overflow  <= overflowNext;
            underflow <= underflowNext;
            if (wrEn) begin
                entries[wrIdx] <= push_addr;
            end
        end
    end

    assign top_addr  = isEmpty ? 64'b0 : entries[topPtr];
    assign top_valid = !isEmpty;
    assign full      = (count == FULL_COUNT);

endmodule

// File: tb/tb_return_addr_stack.sv
module tb_return_addr_stack;

    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic        clk;
    logic        rst;
    logic        push;
    logic [63:0] push_addr;
    logic        pop;
    logic        flush;
    logic [63:0] top_addr;
    logic        top_valid;
    logic [PW:0] count;
    logic        full;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    return_addr_stack #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (push_addr),
        .pop       (pop),
        .flush     (flush),
        .top_addr  (top_addr),
        .top_valid (top_valid),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          push;
        logic [63:0] addr;
        bit          pop;
        bit          flush;
        logic [63:0] eTop;
        int          eCnt;
        bit          eOv;
        bit          eUn;
    } vec_t;

    vec_t vecs[$];

    function automatic void addVec(bit pu, logic [63:0] a, bit po, bit fl,
                                   logic [63:0] eTop, int eCnt, bit eOv, bit eUn);
        vec_t v;
        v.push = pu; v.addr = a; v.pop = po; v.flush = fl;
        v.eTop = eTop; v.eCnt = eCnt; v.eOv = eOv; v.eUn = eUn;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [63:0] eTop, input int eCnt,
                          input bit eOv, input bit eUn);
        chk({tag, " top_addr"},  top_addr, eTop);
        chk({tag, " top_valid"}, 64'(top_valid), 64'(eCnt != 0));
        chk({tag, " count"},     64'(count), 64'(eCnt));
        chk({tag, " full"},      64'(full), 64'(eCnt == DEPTH));
        chk({tag, " overflow"},  64'(overflow), 64'(eOv));
        chk({tag, " underflow"}, 64'(underflow), 64'(eUn));
    endtask

    task automatic drive(input bit pu, input logic [63:0] a, input bit po, input bit fl);
        push = pu; push_addr = a; pop = po; flush = fl;
    endtask

    initial begin
        // Basic push/pop ordering
        addVec(1, 64'h100, 0, 0, 64'h100, 1, 0, 0);
        addVec(1, 64'h200, 0, 0, 64'h200, 2, 0, 0);
        addVec(1, 64'h300, 0, 0, 64'h300, 3, 0, 0);
        addVec(0, 0, 1, 0, 64'h200, 2, 0, 0);
        addVec(0, 0, 1, 0, 64'h100, 1, 0, 0);
        addVec(0, 0, 1, 0, 64'h0,   0, 0, 0);
        // Underflow and push+pop on empty
        addVec(0, 0, 1, 0, 64'h0,  0, 0, 1);
        addVec(0, 0, 0, 0, 64'h0,  0, 0, 0);
        addVec(1, 64'h40, 1, 0, 64'h40, 1, 0, 0);
        addVec(0, 0, 1, 0, 64'h0,  0, 0, 0);
        // Push+pop replaces top in place
        addVec(1, 64'h100, 0, 0, 64'h100, 1, 0, 0);
        addVec(1, 64'h200, 0, 0, 64'h200, 2, 0, 0);
        addVec(1, 64'h500, 1, 0, 64'h500, 2, 0, 0);
        addVec(0, 0, 1, 0, 64'h100, 1, 0, 0);
        addVec(0, 0, 1, 0, 64'h0,   0, 0, 0);
        // Overflow: nine pushes into eight entries, pointer wraps both ways
        for (int k = 1; k <= 9; k++)
            addVec(1, 64'(k * 16), 0, 0, 64'(k * 16), (k > DEPTH) ? DEPTH : k, k > DEPTH, 0);
        addVec(0, 0, 0, 0, 64'h90, 8, 0, 0);
        for (int k = 1; k <= 8; k++)
            addVec(0, 0, 1, 0, (k == 8) ? 64'h0 : 64'((9 - k) * 16), 8 - k, 0, 0);
        addVec(0, 0, 1, 0, 64'h0, 0, 0, 1);
        // Flush beats push, also when full
        for (int k = 1; k <= 5; k++)
            addVec(1, 64'(k), 0, 0, 64'(k), k, 0, 0);
        addVec(1, 64'hAA, 0, 1, 64'h0,  0, 0, 0);
        addVec(1, 64'hBB, 0, 0, 64'hBB, 1, 0, 0);
        for (int k = 2; k <= 8; k++)
            addVec(1, 64'(k), 0, 0, 64'(k), k, 0, 0);
        addVec(1, 64'hCC, 0, 1, 64'h0, 0, 0, 0);
        addVec(0, 0, 1, 1, 64'h0, 0, 0, 0);

        drive(0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chkAll("reset", 64'h0, 0, 0, 0);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].push, vecs[i].addr, vecs[i].pop, vecs[i].flush);
            @(posedge clk); #1;
            chkAll($sformatf("v%0d", i), vecs[i].eTop, vecs[i].eCnt, vecs[i].eOv, vecs[i].eUn);
        end

        // Mid-cycle asynchronous reset with a push pending
        drive(1, 64'h11, 0, 0); @(posedge clk); #1;
        drive(1, 64'h22, 0, 0); @(posedge clk); #1;
        drive(1, 64'h33, 0, 0); @(posedge clk); #1;
        chkAll("preRst", 64'h33, 3, 0, 0);
        drive(1, 64'hDEAD, 0, 0);
        #2 rst = 1'b0;
        #1 chkAll("asyncRst", 64'h0, 0, 0, 0);
        @(posedge clk); #1;
        chkAll("holdRst", 64'h0, 0, 0, 0);
        rst = 1'b1;
        drive(1, 64'h77, 0, 0);
        @(posedge clk); #1;
        chkAll("postRstPush", 64'h77, 1, 0, 0);
        drive(0, 0, 1, 0);
        @(posedge clk); #1;
        chkAll("postRstPop", 64'h0, 0, 0, 0);
        drive(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
